// File: rtl/halt_unit_pkg.sv
// Shared definitions for the halt unit: FSM encodings, the timeout return
// code and the register-index width.
package halt_unit_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [31:0] HALT_TIMEOUT_CODE = 32'hDEAD_0000;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/inflight_tracker.sv
// Saturating up/down counter of instructions between issue and retire,
// with a zero flag for the drain exit test.
module inflight_tracker #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Simultaneous inc/dec cancel; both ends saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/halt_unit.sv
// Halt sequencer: stops fetch, drains in-flight instructions, reads the
// return-value register and presents a sticky isHalt/ret_val pair.
// Optional drain timeout is enabled by defining HALT_TIMEOUT_EN.
module halt_unit
  import halt_unit_pkg::*;
#(
  parameter int RET_REG    = 1,
  parameter int INFLIGHT_W = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt_req,
  input  logic                 issue_valid,
  input  logic                 retire_valid,
  output logic                 stall_fetch,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [31:0]          rf_rdata,
  output logic                 isHalt,
  output logic [31:0]          ret_val,
  output logic [1:0]           fsm_state
);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [INFLIGHT_W-1:0] inflight_cnt;
  logic                  inflight_zero;
  logic                  drain_done;

  // issue_valid/retire_valid are single-cycle events with no back-pressure:
  // each cycle they are high counts exactly one instruction.
  inflight_tracker #(
    .W (INFLIGHT_W)
  ) u_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (issue_valid),
    .dec   (retire_valid),
    .count (inflight_cnt),
    .zero  (inflight_zero)
  );

  assign drain_done = inflight_zero && !issue_valid && !retire_valid;

`ifdef HALT_TIMEOUT_EN
  localparam int DRAIN_W = $clog2(TIMEOUT + 1);

  logic [DRAIN_W-1:0] drain_cnt;
  logic               timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state != ST_DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  assign timeout_hit = (state == ST_DRAIN) && (drain_cnt == DRAIN_W'(TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT != 0) ^ (|inflight_cnt);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (halt_req) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_done) state_nxt = ST_READ;
`ifdef HALT_TIMEOUT_EN
        else if (timeout_hit) state_nxt = ST_HALTED;
`endif
      end
      ST_READ:   state_nxt = ST_HALTED;
      default:   state_nxt = ST_HALTED;
    endcase
  end

  // Outputs are registered from the next state so they flip on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      stall_fetch <= 1'b0;
      isHalt      <= 1'b0;
      ret_val     <= '0;
    end else begin
      state       <= state_nxt;
      stall_fetch <= (state_nxt != ST_RUN);
      isHalt      <= (state_nxt == ST_HALTED);
      if (state == ST_READ) begin
        ret_val <= rf_rdata;
      end
`ifdef HALT_TIMEOUT_EN
      else if ((state == ST_DRAIN) && (state_nxt == ST_HALTED)) begin
        ret_val <= HALT_TIMEOUT_CODE | 32'(inflight_cnt);
      end
`endif
    end
  end

  assign rf_raddr  = (state == ST_READ) ? REG_IDX_W'(RET_REG) : '0;
  assign fsm_state = state;

endmodule
